// File: rtl/noise_tensor_filler_if.sv
// BRAM write-port bundle between the noise filler (master) and the memory (slave).
interface noise_tensor_filler_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic                  bram_we;
  logic                  bram_ready;

  modport master (
    output bram_addr,
    output bram_wdata,
    output bram_we,
    input  bram_ready
  );

  modport slave (
    input  bram_addr,
    input  bram_wdata,
    input  bram_we,
    output bram_ready
  );
endinterface

// File: rtl/noise_tensor_filler.sv
// Fills a BRAM region with LFSR noise, LANES samples per word, over num_ch planes.
// Optional macro NOISE_GAUSS_EN: each lane is the sum of the four signed bytes of its LFSR.
module noise_tensor_filler #(
  parameter int          LANES      = 4,
  parameter int          LANE_WIDTH = 16,
  parameter int          DATA_WIDTH = LANES * LANE_WIDTH,
  parameter int          ADDR_WIDTH = 14,
  parameter int          CH_WIDTH   = 8,
  parameter logic [31:0] SEED       = 32'hACE1_2026
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            size,
  input  logic [CH_WIDTH-1:0]   num_ch,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  noise_tensor_filler_if.master bram,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] POLY_MASK  = 32'h8020_0003;
  localparam logic [31:0] GOLDEN     = 32'h9E37_79B9;
  localparam int          LANE_SHIFT = $clog2(LANES);
  // Product width must hold num_ch * 128*128 and the 2^ADDR_WIDTH limit without truncation.
  localparam int          PW = (CH_WIDTH + 15 > ADDR_WIDTH + 2) ? CH_WIDTH + 15 : ADDR_WIDTH + 2;
  localparam int          CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           lfsr [LANES];
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         w_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         words;
  logic [4:0]            shamt;
  logic                  start_ok;
  logic                  accept;
  logic                  last;
  logic [DATA_WIDTH-1:0] lane_data;

  function automatic logic [31:0] lane_seed(input logic [31:0] s, input int unsigned i);
    logic [31:0] v;
    v = s ^ (32'(i) * GOLDEN);
    return (v == '0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY_MASK) : (s >> 1);
  endfunction

`ifdef NOISE_GAUSS_EN
  function automatic logic [LANE_WIDTH-1:0] lane_value(input logic [31:0] s);
    logic signed [9:0] sum;
    sum = $signed({{2{s[7]}},  s[7:0]})   + $signed({{2{s[15]}}, s[15:8]}) +
          $signed({{2{s[23]}}, s[23:16]}) + $signed({{2{s[31]}}, s[31:24]});
    return LANE_WIDTH'(sum);
  endfunction
`else
  function automatic logic [LANE_WIDTH-1:0] lane_value(input logic [31:0] s);
    return LANE_WIDTH'(s);
  endfunction
`endif

  // side*side = 2^(4+2*size); LANES is a power of two so the divide is a shift.
  always_comb begin
    shamt    = 5'd4 + {1'b0, size, 1'b0};
    prod     = PW'(num_ch) << shamt;
    words    = prod >> LANE_SHIFT;
    start_ok = (size <= 3'd5) && (num_ch != '0) && (words <= (PW'(1) << ADDR_WIDTH));
  end

  assign accept = (state == RUN) && bram.bram_ready;
  assign last   = (cnt == w_q - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && start_ok) state_nxt = RUN;
      RUN:     if (accept && last)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Seed load precedes the fill latch in IDLE so a same-cycle start uses the new seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      w_q    <= '0;
      base_q <= '0;
      err    <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= lane_seed(SEED, i);
    end else begin
      err <= (state == IDLE) && start && !start_ok;
      if (state == IDLE) begin
        if (seed_load) begin
          for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= lane_seed(seed, i);
        end
        if (start && start_ok) begin
          cnt    <= '0;
          w_q    <= CW'(words);
          base_q <= base_addr;
        end
      end else if (accept) begin
        cnt <= cnt + CW'(1);
        for (int unsigned i = 0; i < LANES; i++) lfsr[i] <= lfsr_step(lfsr[i]);
      end
    end
  end

  always_comb begin
    lane_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_data[i*LANE_WIDTH +: LANE_WIDTH] = lane_value(lfsr[i]);
    end
  end

  always_comb begin
    bram.bram_we    = 1'b0;
    bram.bram_addr  = '0;
    bram.bram_wdata = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      RUN: begin
        bram.bram_we    = 1'b1;
        bram.bram_addr  = base_q + cnt[ADDR_WIDTH-1:0];
        bram.bram_wdata = lane_data;
        busy            = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_noise_tensor_filler.sv
// Directed bench for noise_tensor_filler at default parameters.
module tb_noise_tensor_filler;

  localparam logic [31:0] SEED   = 32'hACE1_2026;
  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;
  localparam logic [63:0] SEED_W0 = 64'h4D0D_D354_599F_2026;
  localparam logic [63:0] SEED_W1 = 64'hA685_E9AA_2CCC_9013;
  localparam logic [63:0] ONE_W0  = 64'h6D2A_F373_79B8_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  size = '0;
  logic [7:0]  num_ch = '0;
  logic [13:0] base_addr = '0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic        rdy;
    logic        done;
    logic        err;
    logic        busy;
    logic [13:0] addr;
    logic [63:0] data;
  } rec_t;

  rec_t        tr[$];
  logic [31:0] m [4];

  noise_tensor_filler_if #(.ADDR_WIDTH(14), .DATA_WIDTH(64)) bif ();

  noise_tensor_filler #(.LANES(4), .LANE_WIDTH(16), .ADDR_WIDTH(14), .CH_WIDTH(8), .SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .num_ch    (num_ch),
    .base_addr (base_addr),
    .seed_load (seed_load),
    .seed      (seed),
    .bram      (bif),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic m_seed(input logic [31:0] s);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = s ^ (32'(i) * GOLDEN);
      m[i] = (v == 32'd0) ? 32'd1 : v;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 4; i++) m[i] = m[i][0] ? ((m[i] >> 1) ^ 32'h8020_0003) : (m[i] >> 1);
  endtask

  function automatic logic [63:0] m_word();
    return {m[3][15:0], m[2][15:0], m[1][15:0], m[0][15:0]};
  endfunction

  task automatic load_seed(input logic [31:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    m_seed(s);
  endtask

  // Issues one start and records every following cycle until done or the budget runs out.
  task automatic do_fill(input logic [2:0] sz, input logic [7:0] nc, input logic [13:0] ba,
                         input bit stall, input bit with_seed, input logic [31:0] sd, input int budget);
    rec_t r;
    @(negedge clk);
    size = sz; num_ch = nc; base_addr = ba;
    start = 1'b1; seed_load = with_seed; seed = sd;
    bif.bram_ready = 1'b1;
    tr.delete();
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      seed_load = 1'b0;
      bif.bram_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      r.we = bif.bram_we; r.rdy = bif.bram_ready; r.done = done; r.err = err;
      r.busy = busy; r.addr = bif.bram_addr; r.data = bif.bram_wdata;
      tr.push_back(r);
      if (r.done) break;
    end
  endtask

  task automatic test_reset();
    int we_cnt;
    rst_n = 1'b0;
    bif.bram_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bif.bram_addr !== 14'd0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", bif.bram_addr); end
    vectors++; if (bif.bram_wdata !== 64'd0) begin miscompares++; $display("FAIL rst_wdata: got %h expected 0", bif.bram_wdata); end
    vectors++; if (bif.bram_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b expected 0", bif.bram_we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err); end
    rst_n = 1'b1;
    we_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bif.bram_we !== 1'b0) we_cnt++;
    end
    vectors++; if (we_cnt != 0) begin miscompares++; $display("FAIL idle_we: got %0d write cycles expected 0", we_cnt); end
    m_seed(SEED);
  endtask

  task automatic test_basic_fill();
    logic [63:0] exp;
    do_fill(3'd0, 8'd1, 14'h0100, 1'b0, 1'b0, 32'd0, 20);
    vectors++; if (tr.size() != 5) begin miscompares++; $display("FAIL basic_len: got %0d cycles expected 5", tr.size()); end
    for (int j = 0; j < 4; j++) begin
      exp = (j == 0) ? SEED_W0 : (j == 1) ? SEED_W1 : m_word();
      m_step();
      vectors++; if (tr[j].we !== 1'b1) begin miscompares++; $display("FAIL basic_we[%0d]: got %b expected 1", j, tr[j].we); end
      vectors++; if (tr[j].addr !== 14'h0100 + 14'(j)) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h expected %h", j, tr[j].addr, 14'h0100 + 14'(j)); end
      vectors++; if (tr[j].data !== exp) begin miscompares++; $display("FAIL basic_data[%0d]: got %h expected %h", j, tr[j].data, exp); end
    end
    vectors++; if (tr[0].busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", tr[0].busy); end
    vectors++; if (tr[4].done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b expected 1", tr[4].done); end
    vectors++; if (tr[4].we !== 1'b0) begin miscompares++; $display("FAIL basic_done_we: got %b expected 0", tr[4].we); end
    vectors++; if (tr[4].busy !== 1'b0) begin miscompares++; $display("FAIL basic_done_busy: got %b expected 0", tr[4].busy); end
  endtask

  task automatic test_backpressure();
    int j;
    for (int pass = 0; pass < 2; pass++) begin
      load_seed(32'h1234_5678);
      do_fill(3'd1, 8'd2, 14'h0200, (pass == 0), 1'b0, 32'd0, 200);
      j = 0;
      foreach (tr[k]) begin
        if (tr[k].we === 1'b1) begin
          vectors++; if (tr[k].addr !== 14'h0200 + 14'(j)) begin miscompares++; $display("FAIL bp%0d_addr[%0d]: got %h expected %h", pass, k, tr[k].addr, 14'h0200 + 14'(j)); end
          vectors++; if (tr[k].data !== m_word()) begin miscompares++; $display("FAIL bp%0d_data[%0d]: got %h expected %h", pass, k, tr[k].data, m_word()); end
          if (tr[k].rdy === 1'b1) begin
            j++;
            m_step();
          end
        end
      end
      vectors++; if (j != 32) begin miscompares++; $display("FAIL bp%0d_count: got %0d accepted expected 32", pass, j); end
      vectors++; if (tr[tr.size()-1].done !== 1'b1) begin miscompares++; $display("FAIL bp%0d_done: got %b expected 1", pass, tr[tr.size()-1].done); end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  bad_sz [3] = '{3'd6, 3'd0, 3'd5};
    logic [7:0]  bad_nc [3] = '{8'd1, 8'd0, 8'd5};
    int          n, errs;
    logic [13:0] last_addr;
    bit          got_done;
    for (int c = 0; c < 3; c++) begin
      do_fill(bad_sz[c], bad_nc[c], 14'h0000, 1'b0, 1'b0, 32'd0, 6);
      n = 0;
      foreach (tr[k]) if (tr[k].we !== 1'b0) n++;
      vectors++; if (tr[0].err !== 1'b1) begin miscompares++; $display("FAIL err%0d_pulse: got %b expected 1", c, tr[0].err); end
      vectors++; if (tr[1].err !== 1'b0) begin miscompares++; $display("FAIL err%0d_width: got %b expected 0", c, tr[1].err); end
      vectors++; if (n != 0) begin miscompares++; $display("FAIL err%0d_writes: got %0d expected 0", c, n); end
    end
    // Largest legal fill: exactly 2^14 words, wrapping from 0x0010 to 0x000F.
    do_fill(3'd5, 8'd4, 14'h0010, 1'b0, 1'b0, 32'd0, 16400);
    n = 0;
    last_addr = '0;
    foreach (tr[k]) if (tr[k].we === 1'b1) begin n++; last_addr = tr[k].addr; end
    vectors++; if (tr[0].err !== 1'b0) begin miscompares++; $display("FAIL max_err: got %b expected 0", tr[0].err); end
    vectors++; if (n != 16384) begin miscompares++; $display("FAIL max_count: got %0d expected 16384", n); end
    vectors++; if (last_addr !== 14'h000F) begin miscompares++; $display("FAIL max_last_addr: got %h expected 000f", last_addr); end
    vectors++; if (tr[tr.size()-1].done !== 1'b1) begin miscompares++; $display("FAIL max_done: got %b expected 1", tr[tr.size()-1].done); end
    // Illegal start while running must neither pulse err nor disturb the fill.
    @(negedge clk);
    size = 3'd0; num_ch = 8'd1; base_addr = 14'h0050; start = 1'b1; bif.bram_ready = 1'b1;
    n = 0; errs = 0; got_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k == 0);
      size = 3'd6;
      if (bif.bram_we === 1'b1) n++;
      if (err === 1'b1) errs++;
      if (done === 1'b1) begin got_done = 1'b1; break; end
    end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL busy_writes: got %0d expected 4", n); end
    vectors++; if (errs != 0) begin miscompares++; $display("FAIL busy_err: got %0d pulses expected 0", errs); end
    vectors++; if (got_done !== 1'b1) begin miscompares++; $display("FAIL busy_done: got %b expected 1", got_done); end
    // A legal start during the done cycle is ignored.
    size = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (bif.bram_we !== 1'b0) begin miscompares++; $display("FAIL done_start_we: got %b expected 0", bif.bram_we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_busy: got %b expected 0", busy); end
    do_fill(3'd0, 8'd1, 14'h0000, 1'b0, 1'b0, 32'd0, 20);
    vectors++; if (tr[0].we !== 1'b1) begin miscompares++; $display("FAIL restart_we: got %b expected 1", tr[0].we); end
  endtask

  task automatic test_seed_wrap();
    logic [13:0] exp_addr [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    for (int pass = 0; pass < 2; pass++) begin
      load_seed(32'd1);
      do_fill(3'd0, 8'd1, 14'h0000, 1'b0, 1'b0, 32'd0, 20);
      vectors++; if (tr[0].data !== ONE_W0) begin miscompares++; $display("FAIL seed1_w0_%0d: got %h expected %h", pass, tr[0].data, ONE_W0); end
      for (int j = 0; j < 4; j++) begin
        vectors++; if (tr[j].data !== m_word()) begin miscompares++; $display("FAIL seed1_%0d_data[%0d]: got %h expected %h", pass, j, tr[j].data, m_word()); end
        m_step();
      end
    end
    do_fill(3'd0, 8'd1, 14'h0000, 1'b0, 1'b1, 32'd1, 20);
    vectors++; if (tr[0].data !== ONE_W0) begin miscompares++; $display("FAIL seed_with_start: got %h expected %h", tr[0].data, ONE_W0); end
    do_fill(3'd0, 8'd1, 14'h3FFE, 1'b0, 1'b0, 32'd0, 20);
    for (int j = 0; j < 4; j++) begin
      vectors++; if (tr[j].addr !== exp_addr[j]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h expected %h", j, tr[j].addr, exp_addr[j]); end
    end
  endtask

  task automatic test_reset_mid();
    int  n, seen;
    @(negedge clk);
    size = 3'd2; num_ch = 8'd1; base_addr = 14'h0000; start = 1'b1; bif.bram_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bif.bram_we === 1'b1) n++;
      if (n == 10) break;
    end
    vectors++; if (n != 10) begin miscompares++; $display("FAIL mid_progress: got %0d writes expected 10", n); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bif.bram_we !== 1'b0) begin miscompares++; $display("FAIL mid_we: got %b expected 0", bif.bram_we); end
    vectors++; if (bif.bram_addr !== 14'd0) begin miscompares++; $display("FAIL mid_addr: got %h expected 0", bif.bram_addr); end
    vectors++; if (bif.bram_wdata !== 64'd0) begin miscompares++; $display("FAIL mid_wdata: got %h expected 0", bif.bram_wdata); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || bif.bram_we === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || bif.bram_we === 1'b1) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL mid_quiet: got %0d active cycles expected 0", seen); end
    m_seed(SEED);
    do_fill(3'd0, 8'd1, 14'h0000, 1'b0, 1'b0, 32'd0, 20);
    vectors++; if (tr[0].data !== SEED_W0) begin miscompares++; $display("FAIL mid_reseed: got %h expected %h", tr[0].data, SEED_W0); end
    vectors++; if (tr[4].done !== 1'b1) begin miscompares++; $display("FAIL mid_refill_done: got %b expected 1", tr[4].done); end
  endtask

  initial begin
    bif.bram_ready = 1'b1;
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_errors();
    test_seed_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noise_tensor_filler.md
Name: noise_tensor_filler

Overview:
- Parametrised successor to the single-plane noise filler.
- Fills a BRAM region with pseudo-random noise for GAN noise-injection layers.
- Supports multiple channels, a configurable base address, reseeding, and write backpressure.
- Sits between the layer controller (start/done) and a BRAM write port; one word packs LANES independent noise samples.

Parameters:
- LANES, 4, noise samples per BRAM word; power of 2, 1..16.
- LANE_WIDTH, 16, bits per sample; 1..32.
- DATA_WIDTH, LANES*LANE_WIDTH, BRAM word width (derived; 64 at defaults).
- ADDR_WIDTH, 14, BRAM word address width.
- CH_WIDTH, 8, width of the channel-count input.
- SEED, 32'hACE1_2026, reset seed for the LFSR bank.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle fill request; sampled in IDLE only.
- size  in  3  plane side = 4<<size; codes 0..5 (4..128) are legal.
- num_ch  in  CH_WIDTH  number of channels; must be >0.
- base_addr  in  ADDR_WIDTH  first word address.
- seed_load  in  1  load seed into the LFSR bank; honoured in IDLE only.
- seed  in  32  seed value.
- bram_ready  in  1  BRAM accepts the write this cycle.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_wdata  out  DATA_WIDTH  write data.
- bram_we  out  1  write valid.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: bram_addr=0, bram_wdata=0, bram_we=0, busy=0, done=0, err=0, FSM=IDLE, counter=0. Lane i LFSR = SEED ^ (i*32'h9E3779B9); a zero result is replaced by 1.
- Total words: W = (side*side*num_ch)/LANES. Computed at start with width ADDR_WIDTH+CH_WIDTH+1, no truncation.
- Start rejection: start with size>5, num_ch==0, or W > 2^ADDR_WIDTH.
  - err=1 for one cycle, no writes, FSM stays IDLE.
- FSM IDLE:
  - Legal start latches size, num_ch, base_addr and W; clears the counter; goes to RUN.
  - bram_we rises the next cycle with bram_addr=base_addr (1-cycle start latency).
- FSM RUN:
  - bram_we=1, bram_addr = (base_addr + cnt) mod 2^ADDR_WIDTH; the address wraps silently.
  - Write accepted when bram_we && bram_ready: cnt++ and every lane LFSR steps once.
  - With bram_ready=0: addr, wdata and we hold stable and the LFSRs do not step.
  - The accept of word W-1 moves to DONE.
- FSM DONE: done=1, busy=0, bram_we=0 for one cycle, then IDLE. The next start is accepted in the following cycle.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003).
  - Lane i occupies bram_wdata[i*LANE_WIDTH +: LANE_WIDTH] = state_i[LANE_WIDTH-1:0].
  - Lane 0 is in the LSBs.
  - LFSR state carries over between fills; it is not reset per fill.
- seed_load in IDLE reloads lane i with seed ^ (i*32'h9E3779B9), applying the zero→1 rule.
  - seed_load and start in the same cycle: the seed is applied first, and the fill's first word uses the new seed.
- start and seed_load while busy (RUN/DONE) are ignored; no err pulse.
- Async reset mid-fill: immediate return to reset state. done is not issued and no further writes occur.

Optional Feature:
- Macro NOISE_GAUSS_EN.
- Defined: each lane value is the sum of the four signed bytes of state_i (range -512..508), sign-extended or truncated to LANE_WIDTH. This gives an approximately Gaussian distribution; timing is unchanged.
- Undefined: uniform output, state_i[LANE_WIDTH-1:0].

Test Plan:
- Reset values: hold rst_n=0 → all outputs 0. Release, no start → bram_we stays 0 for 50 cycles.
- Basic fill: size=0, num_ch=1, base_addr=0x0100, bram_ready=1 → exactly 4 writes at 0x0100..0x0103 on consecutive cycles; first write the cycle after start; done pulses the cycle after the 4th write.
- Backpressure: size=1, num_ch=2 (W=32), bram_ready toggled 1,0,0,1… → 32 accepted writes. Data/address held during stalls; the accepted-word sequence is identical to a no-stall run with the same seed.
- Errors: size=6 → err pulse, no writes. num_ch=0 → err. size=5, num_ch=5 (W=20480>16384) → err. Start while busy → ignored.
- Seed repeatability and wrap: seed_load seed=1, fill size=0 twice with reseed between → identical data. base_addr=0x3FFE, W=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Reset mid-fill: deassert rst_n after 10 writes of a W=64 fill → outputs 0 immediately, no done. A new fill afterwards starts from the SEED-derived LFSR state.
